// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between IF and MEM; DM has fixed priority.
// Latency: grant -> MEM_LAT enable cycles -> one-cycle ready pulse; requesters wait via stall_if/stall_mem.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [1:0]    dm_len,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic [31:0]   dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_len,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          busy
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be within 1..15");
    end

    typedef enum logic {IDLE, ACCESS} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    typedef struct packed {
        logic          we;
        logic [1:0]    len;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } req_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    owner_t      owner, owner_nxt;
    logic [3:0]  cnt, cnt_nxt;
    req_t        lat, lat_nxt;
    logic [31:0] if_rdata_nxt, dm_rdata_nxt;
    logic        if_ready_nxt, dm_ready_nxt;
    logic        eff_dm, eff_if;

    // A port is masked in its own ready cycle so it cannot be re-granted on a stale request.
    assign eff_dm = dm_req & ~dm_ready;
    assign eff_if = if_req & ~if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            cnt      <= '0;
            lat      <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            cnt      <= cnt_nxt;
            lat      <= lat_nxt;
            if_rdata <= if_rdata_nxt;
            dm_rdata <= dm_rdata_nxt;
            if_ready <= if_ready_nxt;
            dm_ready <= dm_ready_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        cnt_nxt      = cnt;
        lat_nxt      = lat;
        if_rdata_nxt = if_rdata;
        dm_rdata_nxt = dm_rdata;
        if_ready_nxt = 1'b0;
        dm_ready_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (eff_dm) begin
                    owner_nxt     = OWN_DM;
                    lat_nxt.we    = dm_we;
                    lat_nxt.len   = dm_len;
                    lat_nxt.addr  = dm_addr;
                    lat_nxt.wdata = dm_wdata;
                    cnt_nxt       = CNT_INIT;
                    state_nxt     = ACCESS;
                end else if (eff_if) begin
                    owner_nxt     = OWN_IF;
                    lat_nxt.we    = 1'b0;
                    lat_nxt.len   = 2'b11;
                    lat_nxt.addr  = if_addr;
                    lat_nxt.wdata = '0;
                    cnt_nxt       = CNT_INIT;
                    state_nxt     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                    if (owner == OWN_IF) begin
                        if_ready_nxt = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end else begin
                        dm_ready_nxt = 1'b1;
                        if (!lat.we) begin
                            dm_rdata_nxt = mem_rdata;
                        end
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_en    = (state == ACCESS);
    assign busy      = mem_en;
    assign mem_we    = mem_en & lat.we;
    assign mem_len   = lat.len;
    assign mem_addr  = lat.addr;
    assign mem_wdata = lat.wdata;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 3, 1) share stimulus; one is observed per test.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        dm;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [1:0]  dm_len;

    logic [31:0] if_rdata [3];
    logic [31:0] dm_rdata [3];
    logic        if_ready [3];
    logic        dm_ready [3];
    logic        mem_en   [3];
    logic        mem_we   [3];
    logic [1:0]  mem_len  [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata[3];
    logic        stall_if [3];
    logic        stall_mem[3];
    logic        busy     [3];

    int   vectors = 0;
    int   miscompares = 0;
    int   sel = 0;
    logic mon_en = 1'b0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
        mem_port_arbiter #(.MEM_LAT(LAT), .AW(32)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
            .dm_req(dm_req), .dm_we(dm_we), .dm_len(dm_len), .dm_addr(dm_addr),
            .dm_wdata(dm_wdata), .dm_rdata(dm_rdata[g]), .dm_ready(dm_ready[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_len(mem_len[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata),
            .stall_if(stall_if[g]), .stall_mem(stall_mem[g]), .busy(busy[g])
        );
    end

    // Scoreboard monitor: every ready pulse of the observed instance must match the queue head.
    always @(posedge clk) begin
        #3;
        if (mon_en && !rst) begin
            if (if_ready[sel] && dm_ready[sel]) begin
                vectors++;
                miscompares++;
                $display("FAIL both_ready dut=%0d: if_ready and dm_ready high together", sel);
            end else if (if_ready[sel] || dm_ready[sel]) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_ready dut=%0d: got if=%b dm=%b, required none", sel, if_ready[sel], dm_ready[sel]);
                end else begin
                    exp_t e;
                    logic [31:0] got;
                    e   = sbq.pop_front();
                    got = dm_ready[sel] ? dm_rdata[sel] : if_rdata[sel];
                    if (dm_ready[sel] !== e.dm || got !== e.data) begin
                        miscompares++;
                        $display("FAIL sb_rdata dut=%0d: got dm=%b data=%h, required dm=%b data=%h",
                                 sel, dm_ready[sel], got, e.dm, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push_exp(input logic dm, input logic [31:0] data);
        exp_t e;
        e.dm   = dm;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic clear_inputs();
        if_req = 0; dm_req = 0; dm_we = 0; dm_len = 2'b00;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    endtask

    task automatic do_reset(input int s);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        sel = s;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 2) rst = 1'b0;
            #2;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (c < 2 && (if_ready[k] !== 1'b0 || dm_ready[k] !== 1'b0 || if_rdata[k] !== 32'h0 ||
                              dm_rdata[k] !== 32'h0 || mem_en[k] !== 1'b0 || mem_we[k] !== 1'b0 ||
                              busy[k] !== 1'b0 || mem_addr[k] !== 32'h0 || mem_wdata[k] !== 32'h0 ||
                              mem_len[k] !== 2'b00)) begin
                    miscompares++;
                    $display("FAIL reset_vals dut=%0d c=%0d: got rdy=%b%b en=%b busy=%b addr=%h, required all 0",
                             k, c, if_ready[k], dm_ready[k], mem_en[k], busy[k], mem_addr[k]);
                end
                if (c == 2 && mem_en[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_release dut=%0d: got mem_en=%b, required 0", k, mem_en[k]);
                end
                if (c == 3 && (mem_en[k] !== 1'b1 || busy[k] !== 1'b1 || mem_addr[k] !== 32'h40)) begin
                    miscompares++;
                    $display("FAIL reset_first_grant dut=%0d: got en=%b busy=%b addr=%h, required 1 1 00000040",
                             k, mem_en[k], busy[k], mem_addr[k]);
                end
            end
        end
    endtask

    task automatic test_if_read();
        do_reset(0);
        for (int c = 0; c < 5; c++) begin
            logic e_en;
            @(posedge clk); #1;
            if (c == 0) begin
                if_req = 1; if_addr = 32'h00400000; mem_rdata = 32'h2402000A;
                push_exp(1'b0, 32'h2402000A);
            end
            if (c == 3) if_req = 0;
            #2;
            e_en = (c == 1 || c == 2);
            vectors++;
            if (mem_en[0] !== e_en || busy[0] !== e_en || (e_en && (mem_addr[0] !== 32'h00400000 ||
                mem_we[0] !== 1'b0 || mem_len[0] !== 2'b11))) begin
                miscompares++;
                $display("FAIL if_read_mem c=%0d: got en=%b we=%b len=%b addr=%h, required en=%b we=0 len=11 addr=00400000",
                         c, mem_en[0], mem_we[0], mem_len[0], mem_addr[0], e_en);
            end
            vectors++;
            if (if_ready[0] !== (c == 3) || stall_if[0] !== (c <= 2)) begin
                miscompares++;
                $display("FAIL if_read_hs c=%0d: got ready=%b stall=%b, required ready=%b stall=%b",
                         c, if_ready[0], stall_if[0], (c == 3), (c <= 2));
            end
        end
        vectors++;
        if (if_rdata[0] !== 32'h2402000A) begin
            miscompares++;
            $display("FAIL if_read_hold: got if_rdata=%h, required 2402000a", if_rdata[0]);
        end
    endtask

    task automatic test_priority();
        do_reset(0);
        for (int c = 0; c < 8; c++) begin
            logic e_en;
            @(posedge clk); #1;
            if (c == 0) begin
                if_req = 1; if_addr = 32'h00400010;
                dm_req = 1; dm_we = 0; dm_len = 2'b11; dm_addr = 32'h100;
                mem_rdata = 32'hAAAA0001;
                push_exp(1'b1, 32'hAAAA0001);
                push_exp(1'b0, 32'hBBBB0002);
            end
            if (c == 3) dm_req = 0;
            if (c == 4) mem_rdata = 32'hBBBB0002;
            if (c == 6) if_req = 0;
            #2;
            e_en = (c == 1 || c == 2 || c == 4 || c == 5);
            vectors++;
            if (mem_en[0] !== e_en) begin
                miscompares++;
                $display("FAIL prio_en c=%0d: got %b, required %b", c, mem_en[0], e_en);
            end
            if (e_en) begin
                vectors++;
                if (mem_addr[0] !== ((c < 3) ? 32'h100 : 32'h00400010)) begin
                    miscompares++;
                    $display("FAIL prio_addr c=%0d: got %h, required %h", c, mem_addr[0], (c < 3) ? 32'h100 : 32'h00400010);
                end
            end
            vectors++;
            if (dm_ready[0] !== (c == 3) || if_ready[0] !== (c == 6) ||
                stall_if[0] !== (c <= 5) || stall_mem[0] !== (c <= 2)) begin
                miscompares++;
                $display("FAIL prio_hs c=%0d: got dr=%b ir=%b sif=%b smem=%b, required %b %b %b %b", c,
                         dm_ready[0], if_ready[0], stall_if[0], stall_mem[0], (c == 3), (c == 6), (c <= 5), (c <= 2));
            end
        end
    endtask

    task automatic test_dm_write();
        do_reset(0);
        for (int c = 0; c < 9; c++) begin
            logic e_we;
            @(posedge clk); #1;
            if (c == 0) begin
                dm_req = 1; dm_we = 0; dm_len = 2'b11; dm_addr = 32'h300; mem_rdata = 32'h1234;
                push_exp(1'b1, 32'h1234);
            end
            if (c == 3) dm_req = 0;
            if (c == 4) begin
                dm_req = 1; dm_we = 1; dm_len = 2'b01; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
                mem_rdata = 32'hFFFFFFFF;
                push_exp(1'b1, 32'h1234);
            end
            if (c == 5) begin dm_addr = 32'h999; dm_wdata = 32'h0; end
            if (c == 7) dm_req = 0;
            #2;
            e_we = (c == 5 || c == 6);
            vectors++;
            if (mem_we[0] !== e_we || mem_en[0] !== (c == 1 || c == 2 || e_we)) begin
                miscompares++;
                $display("FAIL wr_we c=%0d: got we=%b en=%b, required we=%b", c, mem_we[0], mem_en[0], e_we);
            end
            if (e_we) begin
                vectors++;
                if (mem_addr[0] !== 32'h200 || mem_wdata[0] !== 32'hDEADBEEF || mem_len[0] !== 2'b01) begin
                    miscompares++;
                    $display("FAIL wr_fields c=%0d: got addr=%h wdata=%h len=%b, required 00000200 deadbeef 01",
                             c, mem_addr[0], mem_wdata[0], mem_len[0]);
                end
            end
            vectors++;
            if (dm_ready[0] !== (c == 3 || c == 7)) begin
                miscompares++;
                $display("FAIL wr_ready c=%0d: got %b, required %b", c, dm_ready[0], (c == 3 || c == 7));
            end
        end
        vectors++;
        if (dm_rdata[0] !== 32'h1234) begin
            miscompares++;
            $display("FAIL wr_rdata_hold: got %h, required 00001234", dm_rdata[0]);
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset(1);
        for (int c = 0; c < 15; c++) begin
            logic e_en;
            @(posedge clk); #1;
            case (c)
                0: begin if_req = 1; if_addr = 32'h00400000; mem_rdata = 32'h77; push_exp(1'b0, 32'h77); end
                4: if_req = 0;
                5: begin if_req = 1; if_addr = 32'h00400020; mem_rdata = 32'h88; end
                7: rst = 1'b1;
                8: begin rst = 1'b0; if_req = 0; end
                9: begin if_req = 1; if_addr = 32'h00400040; mem_rdata = 32'h99; push_exp(1'b0, 32'h99); end
                13: if_req = 0;
                default: ;
            endcase
            #2;
            e_en = (c inside {1, 2, 3, 6, 7, 10, 11, 12});
            vectors++;
            if (mem_en[1] !== e_en || if_ready[1] !== (c == 4 || c == 13)) begin
                miscompares++;
                $display("FAIL rstmid c=%0d: got en=%b ready=%b, required en=%b ready=%b",
                         c, mem_en[1], if_ready[1], e_en, (c == 4 || c == 13));
            end
            if (c == 6 || c == 8 || c == 14) begin
                logic [31:0] e_rd;
                e_rd = (c == 6) ? 32'h77 : ((c == 8) ? 32'h0 : 32'h99);
                vectors++;
                if (if_rdata[1] !== e_rd || (c == 8 && busy[1] !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL rstmid_rdata c=%0d: got rdata=%h busy=%b, required rdata=%h", c, if_rdata[1], busy[1], e_rd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        for (int c = 0; c < 14; c++) begin
            logic e_en;
            @(posedge clk); #1;
            mem_rdata = 32'h6000 + 32'(c);
            if (c == 0) begin dm_req = 1; dm_we = 0; dm_len = 2'b10; dm_addr = 32'h500; if_addr = 32'h00400080; end
            if (c == 4) if_req = 1;
            if (c == 8) if_req = 0;
            if (c == 13) dm_req = 0;
            if (c == 0 || c == 3 || c == 7 || c == 10) push_exp(1'b1, 32'h6000 + 32'(c + 1));
            if (c == 5) push_exp(1'b0, 32'h6006);
            #2;
            e_en = (c inside {1, 4, 6, 8, 11});
            vectors++;
            if (mem_en[2] !== e_en || dm_ready[2] !== (c inside {2, 5, 9, 12}) || if_ready[2] !== (c == 7)) begin
                miscompares++;
                $display("FAIL b2b c=%0d: got en=%b dr=%b ir=%b, required en=%b dr=%b ir=%b", c, mem_en[2],
                         dm_ready[2], if_ready[2], e_en, (c inside {2, 5, 9, 12}), (c == 7));
            end
            if (e_en) begin
                vectors++;
                if (mem_addr[2] !== ((c == 6) ? 32'h00400080 : 32'h500)) begin
                    miscompares++;
                    $display("FAIL b2b_addr c=%0d: got %h, required %h", c, mem_addr[2], (c == 6) ? 32'h00400080 : 32'h500);
                end
            end
            vectors++;
            if (stall_if[2] !== (c >= 4 && c <= 6)) begin
                miscompares++;
                $display("FAIL b2b_stall_if c=%0d: got %b, required %b", c, stall_if[2], (c >= 4 && c <= 6));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        if_req = 1; dm_req = 1; dm_we = 0; dm_len = 2'b11;
        dm_addr = 32'h40; if_addr = 32'h00400000;
        test_reset();
        test_if_read();
        test_priority();
        test_dm_write();
        test_reset_mid_access();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #3;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending expected results, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
